// File: rtl/kb_scr_link_peer.sv
// Far-end peer of the keyboard/screen parallel link: 4-phase REQ/ACK both ways, FIFO-decoupled.
// Optional TX handshake watchdog enabled by defining KB_SCR_PEER_TIMEOUT_EN.

module kb_scr_peer_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wptr, r_rptr;
  logic         w_do_push, w_do_pop;

  // Extra pointer MSB separates full (MSBs differ) from empty (equal).
  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_data    = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_data;
  end
endmodule

module kb_scr_link_peer #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_link_data,
  input  logic [1:0] i_link_ctrl,
  output logic [7:0] o_link_data,
  output logic [1:0] o_link_ctrl,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  input  logic       i_rx_ready,
  output logic       o_tx_busy,
  output logic       o_timeout_err
);
  typedef enum logic {RX_IDLE, RX_ACK} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_SETUP, TX_REQ, TX_REL} tx_state_t;

  rx_state_t  r_rx_state, w_rx_next;
  tx_state_t  r_tx_state, w_tx_next;
  logic [1:0] r_ctrl_s1, r_ctrl_s2;
  logic [7:0] r_link_data;
  logic       w_req_s, w_ack_s;
  logic       w_rx_push, w_rx_full, w_rx_empty;
  logic       w_tx_pop, w_tx_full, w_tx_empty;
  logic [7:0] w_tx_head;
  logic       w_to_hit;

  assign w_req_s = r_ctrl_s2[0];
  assign w_ack_s = r_ctrl_s2[1];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_ctrl_s1   <= '0;
      r_ctrl_s2   <= '0;
      r_rx_state  <= RX_IDLE;
      r_tx_state  <= TX_IDLE;
      r_link_data <= '0;
    end else begin
      r_ctrl_s1   <= i_link_ctrl;
      r_ctrl_s2   <= r_ctrl_s1;
      r_rx_state  <= w_rx_next;
      r_tx_state  <= w_tx_next;
      if (w_tx_pop) r_link_data <= w_tx_head;
    end
  end

  // CPU holds link data stable from before REQ until our ACK drops, so no data sync is needed.
  always_comb begin
    w_rx_next = r_rx_state;
    w_rx_push = 1'b0;
    case (r_rx_state)
      RX_IDLE: if (w_req_s && !w_rx_full) begin
        w_rx_push = 1'b1;
        w_rx_next = RX_ACK;
      end
      RX_ACK:  if (!w_req_s) w_rx_next = RX_IDLE;
      default: w_rx_next = RX_IDLE;
    endcase
  end

  always_comb begin
    w_tx_next = r_tx_state;
    w_tx_pop  = 1'b0;
    case (r_tx_state)
      TX_IDLE: if (!w_tx_empty) begin
        w_tx_pop  = 1'b1;
        w_tx_next = TX_SETUP;
      end
      TX_SETUP: w_tx_next = TX_REQ;
      TX_REQ: begin
        if (w_ack_s)       w_tx_next = TX_REL;
        else if (w_to_hit) w_tx_next = TX_IDLE;
      end
      TX_REL: begin
        if (!w_ack_s)      w_tx_next = TX_IDLE;
        else if (w_to_hit) w_tx_next = TX_IDLE;
      end
      default: w_tx_next = TX_IDLE;
    endcase
  end

`ifdef KB_SCR_PEER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_to_cnt;
  logic          r_to_err;
  logic          w_to_run;

  assign w_to_run = (r_tx_state == TX_REQ) || (r_tx_state == TX_REL);
  assign w_to_hit = w_to_run && (r_to_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_to_cnt <= '0;
      r_to_err <= 1'b0;
    end else begin
      r_to_cnt <= (w_to_run && !w_to_hit) ? r_to_cnt + 1'b1 : '0;
      if (w_to_hit) r_to_err <= 1'b1;
    end
  end
  assign o_timeout_err = r_to_err;
`else
  assign w_to_hit      = 1'b0;
  assign o_timeout_err = 1'b0;
`endif

  kb_scr_peer_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_rx_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_rx_push),
    .i_data  (i_link_data),
    .i_pop   (i_rx_ready),
    .o_data  (o_rx_data),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty)
  );

  kb_scr_peer_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_tx_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (i_tx_valid),
    .i_data  (i_tx_data),
    .i_pop   (w_tx_pop),
    .o_data  (w_tx_head),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty)
  );

  assign o_link_data = r_link_data;
  assign o_link_ctrl = {r_rx_state == RX_ACK, r_tx_state == TX_REQ};
  assign o_rx_valid  = !w_rx_empty;
  assign o_tx_ready  = !w_tx_full;
  assign o_tx_busy   = (r_tx_state != TX_IDLE) || !w_tx_empty;
endmodule
